// File: rtl/ps2_letter_events_pkg.sv
// Shared constants for the PS/2 letter-event path: prefix bytes, set-2 letter codes, FSM states.
// Letter index i (A=0 .. Z=25) is the position of its scan code in LETTER_CODES.
package ps2_letter_events_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam int NUM_LETTERS = 26;

  localparam logic [7:0] LETTER_CODES [NUM_LETTERS] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

endpackage

// File: rtl/ps2_scan_to_letter.sv
// Combinational set-2 scan code to letter index lookup; is_letter_o low for any non-letter byte.
module ps2_scan_to_letter
  import ps2_letter_events_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       is_letter_o,
  output logic [4:0] index_o
);

  always_comb begin
    is_letter_o = 1'b0;
    index_o     = 5'd0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (code_i == LETTER_CODES[i]) begin
        is_letter_o = 1'b1;
        index_o     = 5'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_letter_events.sv
// PS/2 set-2 byte stream to one-per-keystroke letter events on a valid/ready handshake.
// `define KEY_REPEAT_EN to pass typematic repeats of the held letter through as extra events.
module ps2_letter_events
  import ps2_letter_events_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [4:0] letter,
  output logic       letter_valid,
  input  logic       letter_ready,
  output logic [4:0] held_letter,
  output logic       held_valid,
  output logic       overrun
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       letter_q, letter_d;
  logic             letter_vld_q, letter_vld_d;
  logic [4:0]       held_letter_q, held_letter_d;
  logic             held_vld_q, held_vld_d;
  logic             overrun_q, overrun_d;

  logic             is_letter;
  logic [4:0]       letter_idx;
  logic             event_gen;

  ps2_scan_to_letter u_decode (
    .code_i      (byte_in),
    .is_letter_o (is_letter),
    .index_o     (letter_idx)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    letter_d      = letter_q;
    letter_vld_d  = letter_vld_q;
    held_letter_d = held_letter_q;
    held_vld_d    = held_vld_q;
    overrun_d     = 1'b0;
    event_gen     = 1'b0;

    if (letter_vld_q && letter_ready) begin
      letter_vld_d = 1'b0;
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    if (byte_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (byte_in == SC_EXT) begin
            state_d = ST_EXT;
          end else if (byte_in == SC_BRK) begin
            state_d = ST_BRK;
          end else if (is_letter) begin
`ifdef KEY_REPEAT_EN
            event_gen = 1'b1;
`else
            event_gen = !held_vld_q || (held_letter_q != letter_idx);
`endif
            held_letter_d = letter_idx;
            held_vld_d    = 1'b1;
          end
        end
        ST_EXT: begin
          state_d = (byte_in == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_BRK: begin
          if (is_letter && held_vld_q && (held_letter_q == letter_idx)) begin
            held_vld_d = 1'b0;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Single-entry buffer: a slot freed this cycle can take the new event.
    if (event_gen) begin
      if (!letter_vld_q || letter_ready) begin
        letter_d     = letter_idx;
        letter_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      letter_q      <= 5'd0;
      letter_vld_q  <= 1'b0;
      held_letter_q <= 5'd0;
      held_vld_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      letter_q      <= letter_d;
      letter_vld_q  <= letter_vld_d;
      held_letter_q <= held_letter_d;
      held_vld_q    <= held_vld_d;
      overrun_q     <= overrun_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = letter_vld_q;
  assign held_letter  = held_letter_q;
  assign held_valid   = held_vld_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/ps2_letter_events.md
# ps2_letter_events

- Converts the raw PS/2 set-2 byte stream from the keyboard receiver into clean, one-per-keystroke letter events (index 0–25) for the encryption path.
- Tracks the E0 (extended) and F0 (break) prefixes and suppresses typematic repeats.
- Ignores non-letter and extended keys.
- Presents each event on a valid/ready handshake, so the downstream rotor/encryption stage consumes exactly one letter per physical key press.

## Interface
- TIMEOUT_CYCLES, 100000: idle clocks after a prefix byte before the prefix is abandoned (1 ms at 100 MHz).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- byte_in  in  8  received scan-code byte.
- byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle.
- letter  out  5  letter index, A=0 … Z=25.
- letter_valid  out  1  event pending; held until accepted.
- letter_ready  in  1  consumer accepts when letter_valid && letter_ready at a rising edge.
- held_letter  out  5  letter currently held down (debug LEDs).
- held_valid  out  1  a letter is currently held.
- overrun  out  1  one-cycle pulse when an event is dropped.

## Operation
- FSM states and transitions:
  - IDLE: E0→EXT, F0→BRK, other bytes are make codes.
  - EXT: F0→EXT_BRK, any other byte is discarded →IDLE.
  - BRK: byte is a break code →IDLE.
  - EXT_BRK: byte discarded →IDLE.
- Letter decode of set-2 codes:
  - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43
  - J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D
  - S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A
  - Everything else is non-letter.
- Make of letter L in IDLE:
  - If !held_valid or held_letter≠L: generate event L, held_letter←L, held_valid←1.
  - If equal: repeat, handled per Configuration.
- Non-letter make: no event; held state unchanged.
- Break of L in BRK: if held_valid && held_letter==L, held_valid←0; otherwise ignored.
- Extended make or break: never generates an event and never changes held state.
- Output buffer is one entry:
  - Event while !letter_valid: load, letter_valid←1.
  - Event while letter_valid && letter_ready in the same cycle: old entry consumed, new entry loaded, letter_valid stays 1.
  - Event while letter_valid && !letter_ready: new event dropped, overrun pulses; held state still updates.
- Prefix timeout: in EXT/BRK/EXT_BRK, a counter runs while byte_valid is low. Reaching TIMEOUT_CYCLES → IDLE with no held-state change. The counter clears on every byte_valid.
- byte_valid in the same cycle as timeout expiry: the byte is processed in the current state, and the timeout is ignored.

## Timing
- Reset values: letter 0, letter_valid 0, held_letter 0, held_valid 0, overrun 0, FSM IDLE, timeout counter 0.
- Latency: letter_valid rises on the clock edge after the cycle in which byte_valid carries the make byte.
- letter is stable while letter_valid is high.
- letter_valid falls on the edge after acceptance unless a new event loads in the same cycle.
- overrun is high for exactly one cycle per dropped event.
- Any pending event, prefix state and held state are discarded immediately on rst_n low.
- Back-to-back byte_valid on consecutive cycles is supported; every byte is processed.

## Configuration
- KEY_REPEAT_EN defined: a repeated make of the currently held letter generates a further event, giving keyboard typematic autorepeat.
- KEY_REPEAT_EN undefined (default): repeats of the held letter are silently suppressed until its break code arrives.

## Structure
- Shared package holds:
  - prefix constants SC_EXT=8'hE0 and SC_BRK=8'hF0;
  - the 26-entry letter scan-code constants;
  - the FSM state typedef.
- One sub-module, ps2_scan_to_letter: purely combinational byte→{is_letter, index[4:0]} lookup, reused by the break-match logic.
- The FSM, timeout counter and output buffer stay in ps2_letter_events.

## Test plan
- Press A, no backpressure. Drive 1C with letter_ready=1 → letter_valid for one cycle with letter=0; held_letter=0, held_valid=1.
- Typematic repeat. Drive 1C,1C,1C then F0,1C → one event without KEY_REPEAT_EN, three with it; after F0,1C, held_valid=0.
- Extended and non-letter keys. Drive E0,1C then E0,F0,1C then 5A → no events; held state unchanged.
- Prefix timeout. Hold A, drive F0, idle TIMEOUT_CYCLES, then 32 → FSM back in IDLE; event letter=1 (B); held_letter=1.
- Backpressure and overrun. With letter_ready=0, drive 1C, then F0,1C, then 32 → letter stays 0 and valid; overrun pulses once. Raise ready → the single entry is consumed and letter_valid falls.
- Reset mid-operation. With an event pending and FSM in BRK, assert rst_n=0 → all outputs at reset values. Release and drive 1C → normal event letter=0.
